cos_dp: RTL and testbench
=========================

COS_DP -- requirements
Module: cos_dp

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset, named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all registers.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 x  input  16  angle, unsigned Q0.16.
REQ-005 y  input  8  term-magnitude threshold in LSBs.
REQ-006 Control inputs, each 1 bit, active-high: toggle, inc_cnt, ld_ps, init_pp, init_ps, init_cnt, init_DFF, ld_y, ld_x2, sel_x, sel_x2, sel_ROM, ld_pp, sel_pp.
REQ-007 cos_bus  output  16  partial-sum register ps (cos x, Q0.16).
REQ-008 cnt_co  output  1  term counter at terminal count.
REQ-009 not_continue  output  1  current term is below threshold.

Function
REQ-010 Registers SHALL be: x2 (16), y_reg (8), pp (16, current term), ps (16, partial sum), cnt (3), s (1, sign DFF).
REQ-011 There SHALL be one combinational 16x16 unsigned multiplier: prod = upper 16 bits of A*B.
REQ-012 Operand A SHALL be x when sel_x=1, else pp.
REQ-013 Operand B SHALL use this priority: x if sel_x; else x2 if sel_x2; else ROM[cnt] if sel_ROM; else 16'hFFFF.
REQ-014 ROM[i] SHALL equal floor(65536/((2i+1)(2i+2))): 0x8000, 0x1555, 0x0888, 0x0492, 0x02D8, 0x01F0, 0x0168, 0x0111 for i=0..7.
REQ-015 ld_y: y_reg <= y.
REQ-016 ld_x2: x2 <= prod.
REQ-017 pp: init_pp loads 16'hFFFF; else if ld_pp, loads prod when sel_pp=1, or 16'hFFFF when sel_pp=0; otherwise holds.
REQ-018 ps: init_ps loads 16'hFFFF; else if ld_ps, loads ps-pp when s=1 or ps+pp when s=0, modulo 2^16, no saturation; otherwise holds.
REQ-019 s: init_DFF sets s=1 (next accumulated term is subtracted); else toggle inverts s.
REQ-020 When ld_ps and toggle are asserted in the same cycle, ps SHALL use the pre-edge value of s.
REQ-021 cnt: init_cnt clears it; else inc_cnt increments it modulo 8.
REQ-022 cnt_co SHALL be combinational: cnt==7.
REQ-023 not_continue SHALL be combinational: pp < {8'h00, y_reg}.
REQ-024 Each init_* signal SHALL take priority over its register's load, increment or toggle.
REQ-025 All loads SHALL take effect on the rising clk edge after assertion; outputs SHALL reflect the new register value in the same cycle; latency 1 cycle.
REQ-026 Simultaneous loads on distinct registers SHALL all take effect, each using the pre-edge register values.
REQ-027 Per-term sequence is set by the controller:
- cycle A: sel_x2+sel_pp+ld_pp;
- cycle B: sel_ROM+sel_pp+ld_pp;
- cycle C: ld_ps+toggle+inc_cnt.
REQ-028 The block SHALL be synthesizable, and the post-synthesis netlist SHALL be cycle-identical to the RTL.

Reset
REQ-029 While rst=0, all registers SHALL be 0 immediately, independent of clk: x2, y_reg, pp, ps, cnt, s.
REQ-030 During reset: cos_bus=0x0000, cnt_co=0, not_continue=0.
REQ-031 Reset asserted mid-operation SHALL abort the computation; after release, init_* signals are required before a new computation.

Verification
REQ-032 Reset: assert rst=0 with arbitrary controls -> cos_bus=0x0000, cnt_co=0, not_continue=0 asynchronously.
REQ-033 Init: one cycle of init_pp, init_ps, init_cnt, init_DFF -> pp=0xFFFF, ps=0xFFFF, cnt=0, s=1.
REQ-034 x-squared and threshold load: x=0x8000, y=0x80, one cycle of sel_x+ld_x2+ld_y -> x2=0x4000, y_reg=0x80.
REQ-035 Term 1: run A,B,C after init -> pp=0x3FFF then 0x1FFF; cos_bus=0xE000; s=0; cnt=1.
REQ-036 Term 2: run A,B,C again -> pp=0x07FF then 0x00AA; cos_bus=0xE0AA; not_continue=0.
REQ-037 Term 3 and counter: a third A,B produces pp=0x0001, giving not_continue=1; separately, 7 inc_cnt pulses after init_cnt give cnt_co=1, and an 8th wraps cnt to 0 and clears cnt_co.

Source files
------------

// File: rtl/cos_dp.sv
// ---------------------------------------------------------------------------
// cos_dp : datapath for a Taylor-series cosine evaluator.
//
// The external controller sequences one series term per three cycles:
//    A : pp <= pp * x^2          (sel_x2 + sel_pp + ld_pp)
//    B : pp <= pp * ROM[cnt]     (sel_ROM + sel_pp + ld_pp)
//    C : ps <= ps -/+ pp, flip sign, advance term counter
//        (ld_ps + toggle + inc_cnt)
// ROM[i] = floor(65536 / ((2i+1)(2i+2))), i.e. the factorial step between
// consecutive even-order terms.  All values are unsigned Q0.16, with
// 16'hFFFF standing in for 1.0.
//
// Ports
//    clk           rising-edge clock
//    rst           asynchronous active-low reset, clears every register
//    x[15:0]       angle, Q0.16
//    y[7:0]        term-magnitude threshold in LSBs
//    toggle .. sel_pp  single-bit active-high controls from the sequencer
//    cos_bus[15:0] partial sum ps (cos x once the series has converged)
//    cnt_co        term counter is at 7
//    not_continue  current term pp is below the threshold
// ---------------------------------------------------------------------------
module cos_dp (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] x,
   input  logic [7:0]  y,
   input  logic        toggle,
   input  logic        inc_cnt,
   input  logic        ld_ps,
   input  logic        init_pp,
   input  logic        init_ps,
   input  logic        init_cnt,
   input  logic        init_DFF,
   input  logic        ld_y,
   input  logic        ld_x2,
   input  logic        sel_x,
   input  logic        sel_x2,
   input  logic        sel_ROM,
   input  logic        ld_pp,
   input  logic        sel_pp,
   output logic [15:0] cos_bus,
   output logic        cnt_co,
   output logic        not_continue
);

   localparam logic [15:0] ONE_Q16 = 16'hFFFF;

   logic [15:0] x2_q, x2_d;
   logic [7:0]  y_reg_q, y_reg_d;
   logic [15:0] pp_q, pp_d;
   logic [15:0] ps_q, ps_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        s_q, s_d;

   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [15:0] rom_data;
   logic [31:0] prod_full;
   logic [15:0] prod;
   logic [15:0] prod_frac_unused;

   // Coefficient ROM indexed by the term counter.
   always_comb begin
      rom_data = 16'h0000;
      case (cnt_q)
         3'd0: rom_data = 16'h8000;
         3'd1: rom_data = 16'h1555;
         3'd2: rom_data = 16'h0888;
         3'd3: rom_data = 16'h0492;
         3'd4: rom_data = 16'h02D8;
         3'd5: rom_data = 16'h01F0;
         3'd6: rom_data = 16'h0168;
         3'd7: rom_data = 16'h0111;
         default: rom_data = 16'h0000;
      endcase
   end

   // Operand muxes: sel_x squares the angle (x * x) for the x2 load.
   always_comb begin
      op_a = sel_x ? x : pp_q;
   end

   always_comb begin
      op_b = ONE_Q16;
      if (sel_x) begin
         op_b = x;
      end else if (sel_x2) begin
         op_b = x2_q;
      end else if (sel_ROM) begin
         op_b = rom_data;
      end
   end

   // Single shared multiplier; the fractional low half is discarded.
   assign prod_full        = {16'h0000, op_a} * {16'h0000, op_b};
   assign prod             = prod_full[31:16];
   assign prod_frac_unused = prod_full[15:0];

   always_comb begin
      x2_d    = x2_q;
      y_reg_d = y_reg_q;
      pp_d    = pp_q;
      ps_d    = ps_q;
      cnt_d   = cnt_q;
      s_d     = s_q;

      if (ld_x2) begin
         x2_d = prod;
      end

      if (ld_y) begin
         y_reg_d = y;
      end

      if (init_pp) begin
         pp_d = ONE_Q16;
      end else if (ld_pp) begin
         pp_d = sel_pp ? prod : ONE_Q16;
      end

      // s_q here is the pre-edge sign, so a same-cycle toggle only affects
      // the next accumulation.
      if (init_ps) begin
         ps_d = ONE_Q16;
      end else if (ld_ps) begin
         ps_d = s_q ? (ps_q - pp_q) : (ps_q + pp_q);
      end

      if (init_DFF) begin
         s_d = 1'b1;
      end else if (toggle) begin
         s_d = ~s_q;
      end

      if (init_cnt) begin
         cnt_d = 3'd0;
      end else if (inc_cnt) begin
         cnt_d = cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x2_q    <= 16'h0000;
         y_reg_q <= 8'h00;
         pp_q    <= 16'h0000;
         ps_q    <= 16'h0000;
         cnt_q   <= 3'd0;
         s_q     <= 1'b0;
      end else begin
         x2_q    <= x2_d;
         y_reg_q <= y_reg_d;
         pp_q    <= pp_d;
         ps_q    <= ps_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
      end
   end

   assign cos_bus      = ps_q;
   assign cnt_co       = (cnt_q == 3'd7);
   assign not_continue = (pp_q < {8'h00, y_reg_q});

endmodule

// File: tb/tb_cos_dp.sv
module tb_cos_dp;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] x;
   logic [7:0]  y;
   logic [13:0] ctrl;
   logic [15:0] cos_bus;
   logic        cnt_co;
   logic        not_continue;

   localparam logic [13:0] TOG    = 14'h0001;
   localparam logic [13:0] INC    = 14'h0002;
   localparam logic [13:0] LDPS   = 14'h0004;
   localparam logic [13:0] IPP    = 14'h0008;
   localparam logic [13:0] IPS    = 14'h0010;
   localparam logic [13:0] ICNT   = 14'h0020;
   localparam logic [13:0] IDFF   = 14'h0040;
   localparam logic [13:0] LDY    = 14'h0080;
   localparam logic [13:0] LDX2   = 14'h0100;
   localparam logic [13:0] SELX   = 14'h0200;
   localparam logic [13:0] SELX2  = 14'h0400;
   localparam logic [13:0] SELROM = 14'h0800;
   localparam logic [13:0] LDPP   = 14'h1000;
   localparam logic [13:0] SELPP  = 14'h2000;
   localparam logic [13:0] INITS  = IPP | IPS | ICNT | IDFF;
   localparam logic [13:0] STEP_A = SELX2 | SELPP | LDPP;
   localparam logic [13:0] STEP_B = SELROM | SELPP | LDPP;
   localparam logic [13:0] STEP_C = LDPS | TOG | INC;

   cos_dp dut (
      .clk          (clk),
      .rst          (rst),
      .x            (x),
      .y            (y),
      .toggle       (ctrl[0]),
      .inc_cnt      (ctrl[1]),
      .ld_ps        (ctrl[2]),
      .init_pp      (ctrl[3]),
      .init_ps      (ctrl[4]),
      .init_cnt     (ctrl[5]),
      .init_DFF     (ctrl[6]),
      .ld_y         (ctrl[7]),
      .ld_x2        (ctrl[8]),
      .sel_x        (ctrl[9]),
      .sel_x2       (ctrl[10]),
      .sel_ROM      (ctrl[11]),
      .ld_pp        (ctrl[12]),
      .sel_pp       (ctrl[13]),
      .cos_bus      (cos_bus),
      .cnt_co       (cnt_co),
      .not_continue (not_continue)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] cos;
      logic        co;
      logic        nc;
   } obs_t;

   typedef struct {
      logic [13:0] ctrl;
      logic [15:0] x;
      logic [7:0]  y;
      obs_t        exp;
   } vec_t;

   vec_t vecs[$];
   obs_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Independent reference model of the datapath registers.
   logic [15:0] m_x2, m_pp, m_ps;
   logic [7:0]  m_y;
   logic [2:0]  m_cnt;
   logic        m_s;

   function automatic obs_t mk(input logic [15:0] c, input logic co, input logic nc);
      obs_t o;
      o.cos = c;
      o.co  = co;
      o.nc  = nc;
      return o;
   endfunction

   function automatic obs_t observed();
      return mk(cos_bus, cnt_co, not_continue);
   endfunction

   function automatic logic [15:0] rom_f(input logic [2:0] i);
      int d;
      d = (2 * int'(i) + 1) * (2 * int'(i) + 2);
      return 16'(65536 / d);
   endfunction

   task automatic model_reset();
      m_x2 = '0; m_pp = '0; m_ps = '0; m_y = '0; m_cnt = '0; m_s = 1'b0;
   endtask

   task automatic model_step(input logic [13:0] c, input logic [15:0] xi, input logic [7:0] yi);
      logic [15:0] a, b, p, n_pp, n_ps;
      logic [31:0] full;
      logic [2:0]  n_cnt;
      logic        n_s;
      a = ((c & SELX) != 0) ? xi : m_pp;
      if ((c & SELX) != 0)        b = xi;
      else if ((c & SELX2) != 0)  b = m_x2;
      else if ((c & SELROM) != 0) b = rom_f(m_cnt);
      else                        b = 16'hFFFF;
      full = 32'(a) * 32'(b);
      p = full[31:16];
      n_pp = m_pp;
      if ((c & IPP) != 0)        n_pp = 16'hFFFF;
      else if ((c & LDPP) != 0)  n_pp = ((c & SELPP) != 0) ? p : 16'hFFFF;
      n_ps = m_ps;
      if ((c & IPS) != 0)        n_ps = 16'hFFFF;
      else if ((c & LDPS) != 0)  n_ps = m_s ? 16'(m_ps - m_pp) : 16'(m_ps + m_pp);
      n_s = m_s;
      if ((c & IDFF) != 0)       n_s = 1'b1;
      else if ((c & TOG) != 0)   n_s = ~m_s;
      n_cnt = m_cnt;
      if ((c & ICNT) != 0)       n_cnt = 3'd0;
      else if ((c & INC) != 0)   n_cnt = 3'(m_cnt + 3'd1);
      if ((c & LDX2) != 0) m_x2 = p;
      if ((c & LDY) != 0)  m_y = yi;
      m_pp = n_pp; m_ps = n_ps; m_s = n_s; m_cnt = n_cnt;
   endtask

   function automatic obs_t model_obs();
      return mk(m_ps, m_cnt == 3'd7, m_pp < {8'h00, m_y});
   endfunction

   task automatic check_obs(input string name, input obs_t got, input obs_t want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got cos_bus=%h cnt_co=%b not_continue=%b, want cos_bus=%h cnt_co=%b not_continue=%b",
                  name, got.cos, got.co, got.nc, want.cos, want.co, want.nc);
      end
   endtask

   // Drive one cycle of stimulus; the expectation is queued now and popped
   // once the DUT has registered the edge.
   task automatic step(input string name, input logic [13:0] c, input logic [15:0] xi,
                       input logic [7:0] yi, input obs_t want);
      ctrl = c; x = xi; y = yi;
      exp_q.push_back(want);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_vec++; n_err++;
         $display("FAIL %s: scoreboard empty, got cos_bus=%h, want an entry", name, cos_bus);
      end else begin
         check_obs(name, observed(), exp_q.pop_front());
      end
   endtask

   task automatic add(input logic [13:0] c, input logic [15:0] xi, input logic [7:0] yi,
                      input logic [15:0] cos, input logic co, input logic nc);
      vec_t v;
      v.ctrl = c; v.x = xi; v.y = yi; v.exp = mk(cos, co, nc);
      vecs.push_back(v);
   endtask

   initial begin
      logic [13:0] c;
      logic [15:0] xi;
      logic [7:0]  yi;

      // Directed computation of cos(0.5 rad) terms with hand-derived results.
      add(INITS,              16'h0000, 8'h00, 16'hFFFF, 1'b0, 1'b0);
      add(SELX | LDX2 | LDY,  16'h8000, 8'h80, 16'hFFFF, 1'b0, 1'b0);
      add(STEP_A,             16'h0000, 8'h00, 16'hFFFF, 1'b0, 1'b0); // pp 3FFF
      add(STEP_B,             16'h0000, 8'h00, 16'hFFFF, 1'b0, 1'b0); // pp 1FFF
      add(STEP_C,             16'h0000, 8'h00, 16'hE000, 1'b0, 1'b0);
      add(STEP_A,             16'h0000, 8'h00, 16'hE000, 1'b0, 1'b0); // pp 07FF
      add(STEP_B,             16'h0000, 8'h00, 16'hE000, 1'b0, 1'b0); // pp 00AA
      add(STEP_C,             16'h0000, 8'h00, 16'hE0AA, 1'b0, 1'b0);
      add(STEP_A,             16'h0000, 8'h00, 16'hE0AA, 1'b0, 1'b1); // pp 002A
      add(STEP_B,             16'h0000, 8'h00, 16'hE0AA, 1'b0, 1'b1); // pp 0001
      add(ICNT,               16'h0000, 8'h00, 16'hE0AA, 1'b0, 1'b1);
      for (int i = 1; i <= 8; i++)
         add(INC, 16'h0000, 8'h00, 16'hE0AA, (i == 7), 1'b1);
      add(LDPP,               16'h0000, 8'h00, 16'hE0AA, 1'b0, 1'b0); // pp FFFF
      add(IDFF | TOG,         16'h0000, 8'h00, 16'hE0AA, 1'b0, 1'b0); // s stays 1
      add(LDPS,               16'h0000, 8'h00, 16'hE0AB, 1'b0, 1'b0); // E0AA-FFFF
      add(IPS | LDPS,         16'h0000, 8'h00, 16'hFFFF, 1'b0, 1'b0);
      add(IPP | LDPP | SELPP | SELX, 16'h1234, 8'h00, 16'hFFFF, 1'b0, 1'b0);
      add(LDPS,               16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0); // FFFF-FFFF
      add(ICNT | INC,         16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0);
      for (int i = 1; i <= 7; i++)
         add(INC, 16'h0000, 8'h00, 16'h0000, (i == 7), 1'b0);

      ctrl = '0; x = '0; y = '0; rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      check_obs("reset_async", observed(), mk(16'h0000, 1'b0, 1'b0));
      ctrl = 14'h3FFF; x = 16'hFFFF; y = 8'hFF;
      @(posedge clk); #1;
      check_obs("reset_held", observed(), mk(16'h0000, 1'b0, 1'b0));
      ctrl = '0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++)
         step($sformatf("vec[%0d]", i), vecs[i].ctrl, vecs[i].x, vecs[i].y, vecs[i].exp);

      // Mid-operation reset: outputs drop before any clock edge.
      step("preload", INITS | LDY, 16'h0000, 8'h10, mk(16'hFFFF, 1'b0, 1'b0));
      step("preload_inc", INC | ICNT, 16'h0000, 8'h00, mk(16'hFFFF, 1'b0, 1'b0));
      rst = 1'b0;
      #1;
      check_obs("midop_reset_async", observed(), mk(16'h0000, 1'b0, 1'b0));
      ctrl = STEP_C | LDY; y = 8'h44;
      @(posedge clk); #1;
      check_obs("midop_reset_held", observed(), mk(16'h0000, 1'b0, 1'b0));
      ctrl = '0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      step("post_reset_idle", 14'h0000, 16'h0000, 8'h00, mk(16'h0000, 1'b0, 1'b0));
      step("post_reset_ldy", LDY, 16'h0000, 8'h05, mk(16'h0000, 1'b0, 1'b1));

      // Randomised traffic against the reference model.
      model_reset();
      model_step(LDY, 16'h0000, 8'h05);
      for (int i = 0; i < 400; i++) begin
         c  = 14'($urandom);
         xi = 16'($urandom);
         yi = 8'($urandom);
         if ($urandom_range(0, 5) != 0) c = c & ~INITS;
         model_step(c, xi, yi);
         step($sformatf("rand[%0d]", i), c, xi, yi, model_obs());
      end

      // Full randomised series run through the normal A/B/C sequence.
      xi = 16'($urandom);
      model_step(INITS, 16'h0000, 8'h00);
      step("series_init", INITS, 16'h0000, 8'h00, model_obs());
      model_step(SELX | LDX2 | LDY, xi, 8'h02);
      step("series_x2", SELX | LDX2 | LDY, xi, 8'h02, model_obs());
      for (int t = 0; t < 8; t++) begin
         model_step(STEP_A, 16'h0000, 8'h00);
         step($sformatf("series_a[%0d]", t), STEP_A, 16'h0000, 8'h00, model_obs());
         model_step(STEP_B, 16'h0000, 8'h00);
         step($sformatf("series_b[%0d]", t), STEP_B, 16'h0000, 8'h00, model_obs());
         model_step(STEP_C, 16'h0000, 8'h00);
         step($sformatf("series_c[%0d]", t), STEP_C, 16'h0000, 8'h00, model_obs());
      end

      if (exp_q.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
